alu_issue_ctrl: RTL and testbench

Front-end sequencer that drives the 3-stage pipelined mini ALU and collects its results.
- Accepts tagged operations over a valid/ready request channel and issues at most one per cycle onto the ALU operand/ctrl inputs.
- Tracks each op through the fixed ALU latency, captures z/zero into a result FIFO and returns it on a valid/ready response channel.
- The ALU cannot stall, so issue is credit-gated so that a captured result always has buffer space.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_result_fifo.sv | 57 +++++
 rtl/alu_issue_ctrl.sv | 101 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the mini-ALU issue controller: op encodings and default sizes.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } alu_op_e;

   localparam int W_DEF     = 4;
   localparam int LAT_DEF   = 3;
   localparam int TW_DEF    = 2;
   localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-facing and response signals of the issue controller, bundled with modports.
interface alu_issue_ctrl_if
   import alu_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int TW = TW_DEF
);
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic [1:0]    req_op;
   logic [TW-1:0] req_tag;

   logic [W-1:0]  alu_a;
   logic [W-1:0]  alu_b;
   logic [1:0]    alu_ctrl;
   logic [W-1:0]  alu_z;
   logic          alu_zero;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_z;
   logic          rsp_zero;
   logic [TW-1:0] rsp_tag;
   logic          zero_err;

   // master: the controller itself
   modport master (
      input  req_valid, req_a, req_b, req_op, req_tag, alu_z, alu_zero, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_z, rsp_zero, rsp_tag, zero_err
   );

   // slave: requester, ALU and consumer around the controller
   modport slave (
      output req_valid, req_a, req_b, req_op, req_tag, alu_z, alu_zero, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_z, rsp_zero, rsp_tag, zero_err
   );

endinterface

// File: rtl/alu_result_fifo.sv
// Show-ahead synchronous FIFO holding captured {z, zero, tag} results.
module alu_result_fifo #(
   parameter  int WIDTH = 7,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CNTW-1:0]  count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [CNTW-1:0]  cnt_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_pop  = pop && (cnt_q != '0);
   assign do_push = push && ((cnt_q != CNTW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_inc(wr_q);
         if (do_pop)  rd_q <= ptr_inc(rd_q);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CNTW'(1);
            2'b01:   cnt_q <= cnt_q - CNTW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= din;
   end

   // Storage is not reset, so the head is masked to zero while empty
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = empty ? '0 : mem[rd_q];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues tagged ops to a fixed-latency pipelined ALU and buffers its results,
// gating issue with credits so a result arriving from the ALU always has FIFO space.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int LAT   = LAT_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int TW    = TW_DEF
) (
   input logic              clk,
   input logic              rst,
   alu_issue_ctrl_if.master bus
);

   localparam int FW   = W + 1 + TW;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int CW   = $clog2(LAT + DEPTH + 1);

   logic [W-1:0]    alu_a_q;
   logic [W-1:0]    alu_b_q;
   logic [1:0]      alu_ctrl_q;
   logic [LAT-1:0]  vld_q;
   logic [TW-1:0]   tag_q [LAT];
   logic            zero_err_q;

   logic            issue;
   logic            cap;
   logic            pop;
   logic [CW-1:0]   credits_used;
   logic [FW-1:0]   fifo_din;
   logic [FW-1:0]   fifo_dout;
   logic [CNTW-1:0] occ;
   logic            fifo_empty;

   // Ops in the ALU plus buffered results never exceed DEPTH
   assign credits_used  = CW'($countones(vld_q)) + CW'(occ);
   assign bus.req_ready = (credits_used < CW'(DEPTH));
   assign issue         = bus.req_valid && bus.req_ready;
   assign cap           = vld_q[LAT-1];
   assign pop           = bus.rsp_valid && bus.rsp_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= '0;
      end else if (issue) begin
         alu_a_q    <= bus.req_a;
         alu_b_q    <= bus.req_b;
         alu_ctrl_q <= bus.req_op;
      end
   end

   // Tag/valid pipe mirrors the ALU depth; it advances every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         vld_q[0] <= issue;
         tag_q[0] <= issue ? bus.req_tag : '0;
         for (int i = LAT - 1; i > 0; i--) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_err_q <= 1'b0;
      end else if (cap && (bus.alu_zero != (bus.alu_z == '0))) begin
         zero_err_q <= 1'b1;
      end
   end

   assign fifo_din = {bus.alu_z, bus.alu_zero, tag_q[LAT-1]};

   alu_result_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (cap),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (occ),
      .empty (fifo_empty)
   );

   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.rsp_valid = !fifo_empty;
   assign {bus.rsp_z, bus.rsp_zero, bus.rsp_tag} = fifo_dout;
   assign bus.zero_err  = zero_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural 3-stage ALU, expected-result queue and monitor.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
   import alu_pkg::*;

   localparam int W     = 4;
   localparam int TW    = 2;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [W-1:0]  z;
      logic          zero;
      logic [TW-1:0] tag;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fault = 1'b0;
   int   total = 0;
   int   bad = 0;
   rsp_t sb[$];

   always #5 clk = ~clk;

   alu_issue_ctrl_if #(.W(W), .TW(TW)) bus ();

   alu_issue_ctrl #(.W(W), .LAT(LAT), .DEPTH(DEPTH), .TW(TW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Environment ALU: two register stages after the DUT's operand registers
   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a ^ b;
      endcase
   endfunction

   logic [W-1:0] s1_q, s2_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
         s2_q <= s1_q;
      end
   end
   assign bus.alu_z    = s2_q;
   assign bus.alu_zero = fault ? 1'b1 : (s2_q == '0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: compare each response handshake against the queue head
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stale_rsp: got z=%0d tag=%0d want no response", bus.rsp_z, bus.rsp_tag);
         end else begin
            e = sb.pop_front();
            $display("rsp  z=%0d zero=%0d tag=%0d (want z=%0d zero=%0d tag=%0d)",
                     bus.rsp_z, bus.rsp_zero, bus.rsp_tag, e.z, e.zero, e.tag);
            check("rsp_z", 32'(bus.rsp_z), 32'(e.z));
            check("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
            check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
         end
      end
      if (!rst && u_dut.cap && (u_dut.occ == DEPTH) && !u_dut.pop) begin
         bad++;
         $display("FAIL fifo_overflow: got push into full FIFO want none");
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic [TW-1:0] tag, input logic [W-1:0] ez, input logic ezero,
                       output int stalls);
      rsp_t e;
      bit   done;
      stalls = 0;
      done = 0;
      bus.req_valid = 1'b1;
      bus.req_a = a;
      bus.req_b = b;
      bus.req_op = op;
      bus.req_tag = tag;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            e.z = ez;
            e.zero = ezero;
            e.tag = tag;
            sb.push_back(e);
            $display("req  a=%0d b=%0d op=%0d tag=%0d", a, b, op, tag);
            done = 1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: got req_ready=0 for 40 cycles want accept");
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.rsp_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st;
      int accepts;
      bus.req_valid = 1'b0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.req_op = '0;
      bus.req_tag = '0;
      bus.rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      check("rst_zero_err", 32'(bus.zero_err), 32'd0);
      check("rst_rsp_z", 32'(bus.rsp_z), 32'd0);
      check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single ADD with latency check
      send(4'd2, 4'd3, 2'b00, 2'd1, 4'd5, 1'b0, st);
      @(negedge clk);
      check("add_alu_a", 32'(bus.alu_a), 32'd2);
      check("add_alu_b", 32'(bus.alu_b), 32'd3);
      check("add_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      repeat (2) @(negedge clk);
      check("lat_rsp_early", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      check("lat_rsp_on_time", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back issue
      send(4'd7, 4'd5, 2'b01, 2'd0, 4'd2, 1'b0, st);
      check("b2b_stall0", 32'(st), 32'd0);
      send(4'd6, 4'd3, 2'b10, 2'd1, 4'd2, 1'b0, st);
      check("b2b_stall1", 32'(st), 32'd0);
      send(4'd9, 4'd5, 2'b11, 2'd2, 4'd12, 1'b0, st);
      check("b2b_stall2", 32'(st), 32'd0);
      drain();

      // Zero results and wrap-around
      send(4'd5, 4'd5, 2'b01, 2'd3, 4'd0, 1'b1, st);
      send(4'd15, 4'd1, 2'b00, 2'd0, 4'd0, 1'b1, st);
      drain();
      check("zero_err_clean", 32'(bus.zero_err), 32'd0);

      // Backpressure: consumer stalled, requester always valid
      bus.rsp_ready = 1'b0;
      accepts = 0;
      bus.req_valid = 1'b1;
      bus.req_op = 2'b00;
      bus.req_b = 4'd1;
      bus.req_a = 4'd0;
      bus.req_tag = 2'd0;
      for (int c = 0; c < 10; c++) begin
         rsp_t e;
         bit   acc;
         acc = 0;
         @(negedge clk);
         if (bus.req_ready) begin
            e.z = bus.req_a + 4'd1;
            e.zero = 1'b0;
            e.tag = bus.req_tag;
            sb.push_back(e);
            $display("req  a=%0d b=1 op=0 tag=%0d", bus.req_a, bus.req_tag);
            accepts++;
            acc = 1;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            bus.req_a = 4'(accepts);
            bus.req_tag = 2'(accepts);
         end
      end
      bus.req_valid = 1'b0;
      check("bp_accepts", 32'(accepts), 32'd4);
      check("bp_ready_low", 32'(bus.req_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_before_pop", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      drain();

      // Corrupted zero flag
      fault = 1'b1;
      send(4'd1, 4'd2, 2'b00, 2'd3, 4'd3, 1'b1, st);
      drain();
      fault = 1'b0;
      check("zero_err_set", 32'(bus.zero_err), 32'd1);
      send(4'd3, 4'd3, 2'b11, 2'd1, 4'd0, 1'b1, st);
      drain();
      check("zero_err_sticky", 32'(bus.zero_err), 32'd1);

      // Reset with two ops in the ALU and one buffered
      bus.rsp_ready = 1'b0;
      send(4'd1, 4'd1, 2'b00, 2'd0, 4'd2, 1'b0, st);
      @(posedge clk);
      #1;
      send(4'd2, 4'd2, 2'b00, 2'd1, 4'd4, 1'b0, st);
      send(4'd9, 4'd5, 2'b11, 2'd2, 4'd12, 1'b0, st);
      check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      rst = 1'b1;
      sb.delete();
      #1;
      check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
      check("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("mid_rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
      check("mid_rst_zero_err", 32'(bus.zero_err), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      repeat (8) @(negedge clk);
      check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      send(4'd4, 4'd4, 2'b00, 2'd2, 4'd8, 1'b0, st);
      drain();
      check("queue_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
